// File: rtl/xsw_debounce.sv
// Slide-switch input stage: two-flop synchronizer, per-bit debounce, change flags
// with W1C clear, interrupt mask, and a 4-register CPU read/write window.
module xsw_debounce #(
  parameter int DATA_W     = 32,
  parameter int SW_W       = 8,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw_in,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_FLAGS = 2'd1,
    REG_MASK  = 2'd2,
    REG_NONE  = 2'd3
  } reg_e;

  logic [SW_W-1:0]  sync1;
  logic [SW_W-1:0]  sync2;
  logic [SW_W-1:0]  stable;
  logic [SW_W-1:0]  flag;
  logic [SW_W-1:0]  mask;
  logic [CNT_W-1:0] cnt [SW_W];

  logic [SW_W-1:0]  diff;
  logic [SW_W-1:0]  accept;
  logic [SW_W-1:0]  clear;
  logic             wr_mask;
  logic             unused_data;

  // Only the low SW_W data bits are writable; the rest are deliberately ignored.
  assign unused_data = ^{1'b0, data_in};

  assign diff    = sync2 ^ stable;
  assign wr_mask = sel && we && (addr == REG_MASK);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    accept = '0;
    clear  = '0;
    for (int i = 0; i < SW_W; i++) begin
      accept[i] = diff[i] && (cnt[i] == CNT_LAST);
    end
    if (sel && we && (addr == REG_FLAGS)) begin
      clear = data_in[SW_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      flag   <= '0;
      mask   <= '0;
      irq    <= 1'b0;
      // NOTE: the counter array is reset explicitly; a mid-debounce reset must discard counts.
      for (int i = 0; i < SW_W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      for (int i = 0; i < SW_W; i++) begin
        if (!diff[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
      // An accepted bit always differs from stable, so toggling it adopts sync2.
      stable <= stable ^ accept;
      // Set has priority over a same-cycle W1C clear.
      flag   <= (flag & ~clear) | accept;
      if (wr_mask) begin
        mask <= data_in[SW_W-1:0];
      end
      irq <= |(flag & mask);
    end
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      unique case (reg_e'(addr))
        REG_STATE: data_out[SW_W-1:0] = stable;
        REG_FLAGS: data_out[SW_W-1:0] = flag;
        REG_MASK:  data_out[SW_W-1:0] = mask;
        default:   data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_xsw_debounce.sv
// Scoreboard bench for xsw_debounce: directed scenarios plus randomized traffic,
// each cycle's expected read/irq comes from a behavioural model of the switch stage.
module tb_xsw_debounce;

  localparam int DATA_W     = 32;
  localparam int SW_W       = 8;
  localparam int DEB_CYCLES = 4;
  localparam int CNT_W      = 16;

  logic              clk;
  logic              rst;
  logic [SW_W-1:0]   sw_in;
  logic              sel;
  logic              we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              irq;

  xsw_debounce #(
    .DATA_W(DATA_W), .SW_W(SW_W), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .sel(sel), .we(we),
    .addr(addr), .data_in(data_in), .data_out(data_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              irq;
    string             tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: the pin level seen two edges late, and how many
  // consecutive cycles it has disagreed with the accepted level.
  logic [SW_W-1:0] m_pin_d1, m_pin_d2;
  logic [SW_W-1:0] m_stable, m_flag, m_mask;
  logic            m_irq;
  int              m_run [SW_W];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic s, input logic [1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    if (s) begin
      case (a)
        2'd0:    r[SW_W-1:0] = m_stable;
        2'd1:    r[SW_W-1:0] = m_flag;
        2'd2:    r[SW_W-1:0] = m_mask;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic model_edge(input logic [SW_W-1:0] sw, input logic s, input logic w,
                            input logic [1:0] a, input logic [DATA_W-1:0] d, input logic r);
    logic [SW_W-1:0] acc;
    logic [SW_W-1:0] clr;
    if (r) begin
      m_pin_d1 = '0; m_pin_d2 = '0; m_stable = '0;
      m_flag = '0; m_mask = '0; m_irq = 1'b0;
      for (int i = 0; i < SW_W; i++) m_run[i] = 0;
    end else begin
      acc = '0;
      m_irq = |(m_flag & m_mask);
      for (int i = 0; i < SW_W; i++) begin
        if (m_pin_d2[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB_CYCLES) begin
            acc[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      clr = (s && w && a == 2'd1) ? d[SW_W-1:0] : '0;
      m_flag = (m_flag & ~clr) | acc;
      if (s && w && a == 2'd2) m_mask = d[SW_W-1:0];
      for (int i = 0; i < SW_W; i++) if (acc[i]) m_stable[i] = m_pin_d2[i];
      m_pin_d2 = m_pin_d1;
      m_pin_d1 = sw;
    end
  endtask

  // Drive one cycle, queue what the DUT should present during it, then advance the model.
  task automatic cycle(input logic [SW_W-1:0] sw, input logic s, input logic w,
                       input logic [1:0] a, input logic [DATA_W-1:0] d, input logic r,
                       input string tag);
    exp_t e;
    sw_in = sw; sel = s; we = w; addr = a; data_in = d; rst = r;
    e.data = model_read(s, a);
    e.irq  = m_irq;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    model_edge(sw, s, w, a, d, r);
    #1;
  endtask

  task automatic rd(input logic [SW_W-1:0] sw, input logic [1:0] a, input string tag);
    cycle(sw, 1'b1, 1'b0, a, '0, 1'b0, tag);
  endtask

  task automatic wr(input logic [SW_W-1:0] sw, input logic [1:0] a,
                    input logic [DATA_W-1:0] d, input string tag);
    cycle(sw, 1'b1, 1'b1, a, d, 1'b0, tag);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, " data_out"}, data_out, e.data);
      check({e.tag, " irq"}, {{(DATA_W-1){1'b0}}, irq}, {{(DATA_W-1){1'b0}}, e.irq});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW_W-1:0] sw_cur;
    logic [SW_W-1:0] flips;
    logic            s, w, r;
    int              drain;

    sw_in = '0; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0; rst = 1'b1;
    sw_cur = '0;
    // Uncompared reset edges: DUT state is unknown before the first one.
    repeat (2) begin
      @(posedge clk);
      model_edge('0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
    end
    #1;

    // Reset state and the sel=0 bus convention.
    cycle(sw_cur, 1'b1, 1'b0, 2'd0, '0, 1'b1, "reset_hold");
    rd(sw_cur, 2'd0, "reset_state");
    rd(sw_cur, 2'd1, "reset_flags");
    rd(sw_cur, 2'd2, "reset_mask");
    rd(sw_cur, 2'd3, "reset_none");
    for (int a = 0; a < 4; a++) cycle(sw_cur, 1'b0, 1'b0, 2'(a), '0, 1'b0, "unselected");

    // Latency of an accepted rising level on bit 0.
    sw_cur = 8'h01;
    for (int k = 0; k < 9; k++) rd(sw_cur, 2'd0, "latency_state");
    rd(sw_cur, 2'd1, "latency_flags");

    // Three-cycle glitch on bit 3 must not be accepted.
    sw_cur = 8'h09;
    repeat (3) rd(sw_cur, 2'd0, "glitch_state");
    sw_cur = 8'h01;
    repeat (8) rd(sw_cur, 2'd1, "glitch_flags");
    sw_cur = 8'h09;
    repeat (3) rd(sw_cur, 2'd0, "glitch_again");
    sw_cur = 8'h01;
    repeat (6) rd(sw_cur, 2'd0, "glitch_settle");

    // Masked interrupt, then clear by W1C; writes to STATE and slot 3 ignored.
    wr(sw_cur, 2'd2, 32'hFFFF_FF01, "mask_write");
    wr(sw_cur, 2'd1, 32'h0000_00FF, "flags_clear_all");
    wr(sw_cur, 2'd0, 32'hFFFF_FFFF, "state_write_ignored");
    wr(sw_cur, 2'd3, 32'hFFFF_FFFF, "none_write_ignored");
    sw_cur = 8'h00;
    repeat (9) rd(sw_cur, 2'd1, "irq_raise");
    wr(sw_cur, 2'd1, 32'h0000_0001, "irq_w1c");
    repeat (3) rd(sw_cur, 2'd1, "irq_drop");

    // W1C of flag 2 on the very edge it is set: the set wins.
    sw_cur = 8'h04;
    repeat (5) rd(sw_cur, 2'd0, "setwins_wait");
    wr(sw_cur, 2'd1, 32'h0000_0004, "setwins_w1c");
    repeat (2) rd(sw_cur, 2'd1, "setwins_flags");

    // Reset two cycles into a debounce of bit 1, then full re-acquisition.
    sw_cur = 8'h06;
    repeat (2) rd(sw_cur, 2'd0, "midreset_pre");
    cycle(sw_cur, 1'b1, 1'b0, 2'd0, '0, 1'b1, "midreset_pulse");
    repeat (10) rd(sw_cur, 2'd0, "midreset_state");
    repeat (2) rd(sw_cur, 2'd1, "midreset_flags");

    // Randomized traffic: occasional pin flips, random register accesses, rare resets.
    for (int n = 0; n < 3000; n++) begin
      flips = '0;
      for (int i = 0; i < SW_W; i++) flips[i] = ($urandom_range(0, 99) < 8);
      sw_cur = sw_cur ^ flips;
      s = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 499) == 0);
      cycle(sw_cur, s, w, 2'($urandom_range(0, 3)), $urandom, r, "random");
    end
    sel = 1'b0; we = 1'b0; rst = 1'b0;

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
